// File: rtl/ntt_pkg.sv
// Shared constants and index helpers for the NTT datapath.
// Used by the reorder buffer and its index-reversal sub-block.
package ntt_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LOG_N  = 3;
  localparam int IDX_W      = 12;

  function automatic logic [IDX_W-1:0] bitrev(
    input logic [IDX_W-1:0] idx,
    input int               log_n
  );
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < IDX_W; i++) begin
      if (i < log_n) begin
        r[i] = idx[log_n-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_rev_index.sv
// Combinational reversal of all LOG_N bits of a frame index.
// Pure wiring; sits on the read-address path of the reorder buffer.
module bit_rev_index #(
  parameter int LOG_N = 3
) (
  input  logic [LOG_N-1:0] idx,
  output logic [LOG_N-1:0] rev
);

  for (genvar i = 0; i < LOG_N; i++) begin : g_rev
    assign rev[i] = idx[LOG_N-1-i];
  end

endmodule

// File: rtl/stream_bit_reversal.sv
// Ping-pong reorder buffer: frames of N elements in natural order,
// emitted bit-reversed (or natural when the frame was tagged bypass).
module stream_bit_reversal
  import ntt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG_N  = DEF_LOG_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int N = 1 << LOG_N;

  typedef logic [LOG_N-1:0] idx_t;

  localparam idx_t LAST = idx_t'(N - 1);

  logic [DATA_W-1:0] mem [2][N];

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic [1:0] mode;
  logic       wr_bank;
  logic       rd_bank;
  idx_t       wr_cnt;
  idx_t       rd_cnt;
  idx_t       rd_rev;
  idx_t       rd_addr;

  logic wr_fire;
  logic rd_fire;
  logic wr_end;
  logic rd_end;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;
  assign wr_end  = wr_cnt == LAST;
  assign rd_end  = rd_cnt == LAST;

  bit_rev_index #(
    .LOG_N (LOG_N)
  ) u_rev (
    .idx (rd_cnt),
    .rev (rd_rev)
  );

  assign rd_addr  = mode[rd_bank] ? rd_cnt : rd_rev;
  assign out_data = mem[rd_bank][rd_addr];
  assign out_last = out_valid && rd_end;

  // A write only ever targets an empty bank and a read a full one,
  // so set and clear never land on the same bank in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_end) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (rd_fire && rd_end) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full    <= 2'b00;
      mode    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '0) begin
          mode[wr_bank] <= in_bypass;
        end
        if (wr_end) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_end) begin
          rd_bank <= ~rd_bank;
        end
      end
    end
  end

  // Storage carries no reset; stale words are gated by the full flags.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_stream_bit_reversal.sv
// Bench for stream_bit_reversal: vector table, scoreboard monitor,
// hand-written capacity / reset / random / LOG_N=4 sequences.
module tb_stream_bit_reversal;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_bypass;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  logic        v4_in_valid;
  logic        v4_in_ready;
  logic [15:0] v4_in_data;
  logic        v4_out_valid;
  logic        v4_out_ready;
  logic [15:0] v4_out_data;
  logic        v4_out_last;

  always #5 clk = ~clk;

  stream_bit_reversal #(
    .DATA_W (8),
    .LOG_N  (3)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  stream_bit_reversal #(
    .DATA_W (16),
    .LOG_N  (4)
  ) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4_in_valid),
    .in_ready  (v4_in_ready),
    .in_data   (v4_in_data),
    .in_bypass (1'b0),
    .out_valid (v4_out_valid),
    .out_ready (v4_out_ready),
    .out_data  (v4_out_data),
    .out_last  (v4_out_last)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0] din [8];
    logic       byp;
    logic [7:0] exp [8];
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       sb [$];
  logic [7:0] obs [$];
  bit         rnd_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  int         m_cnt = 0;
  logic       m_byp = 1'b0;
  logic [7:0] m_frm [8];
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_cnt      = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (in_valid && in_ready) begin
        if (m_cnt == 0) m_byp = in_bypass;
        m_frm[m_cnt] = in_data;
        if (m_cnt == 7) begin
          for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.data = m_byp ? m_frm[i] : m_frm[rev3(i)];
            e.last = (i == 7);
            sb.push_back(e);
          end
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        obs.push_back(out_data);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got %0h expected no output",
                   out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", 32'(out_data), 32'(e.data));
          chk("sb_last", 32'(out_last), 32'(e.last));
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic byp);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_bypass = byp;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    out_ready = 1'b1;
    for (int c = 0; c < 300 && (sb.size() != 0 || out_valid); c++) begin
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t tv [3];
  logic [7:0]  rst_exp [8];
  logic [15:0] exp4 [16];

  initial begin
    int acc;
    int k16;
    int first_low;
    int got4;

    tv[0].din = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tv[0].byp = 1'b0;
    tv[0].exp = '{8'd1, 8'd5, 8'd3, 8'd7, 8'd2, 8'd6, 8'd4, 8'd8};
    tv[1].din = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tv[1].byp = 1'b1;
    tv[1].exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    tv[2].din = '{8'd11, 8'd12, 8'd13, 8'd14,
                  8'd15, 8'd16, 8'd17, 8'd18};
    tv[2].byp = 1'b0;
    tv[2].exp = '{8'd11, 8'd15, 8'd13, 8'd17,
                  8'd12, 8'd16, 8'd14, 8'd18};
    rst_exp = '{8'd9, 8'd13, 8'd11, 8'd15,
                8'd10, 8'd14, 8'd12, 8'd16};
    exp4 = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
             16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_bypass    = 1'b0;
    out_ready    = 1'b1;
    v4_in_valid  = 1'b0;
    v4_in_data   = '0;
    v4_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: mode bit flips after element 0 and must be ignored.
    for (int v = 0; v < 3; v++) begin
      obs.delete();
      for (int i = 0; i < 8; i++) begin
        send(tv[v].din[i], (i == 0) ? tv[v].byp : ~tv[v].byp);
        if (i == 6) chk("lat_not_yet", 32'(out_valid), 32'd0);
      end
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_first", 32'(out_data), 32'(tv[v].exp[0]));
      wait_drain();
      chk("tv_count", 32'(obs.size()), 32'd8);
      for (int i = 0; i < 8 && i < obs.size(); i++) begin
        chk($sformatf("tv%0d_out%0d", v, i), 32'(obs[i]),
            32'(tv[v].exp[i]));
      end
    end

    // Capacity: 24 offered with out_ready low.
    out_ready = 1'b0;
    acc       = 0;
    k16       = -1;
    first_low = -1;
    for (int it = 0; it < 80 && acc < 24; it++) begin
      in_valid  = 1'b1;
      in_data   = 8'(21 + acc);
      in_bypass = 1'b0;
      if (it == 24) out_ready = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        if (acc == 16) k16 = it;
      end else if (first_low < 0) begin
        first_low = it;
      end
      if (it == 23) chk("cap_accepted", 32'(acc), 32'd16);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("cap_low_cycle", 32'(first_low), 32'(k16 + 1));
    chk("cap_total", 32'(acc), 32'd24);
    wait_drain();

    // Random out_ready and input gaps over three frames.
    rnd_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send(8'(50 + f * 8 + i), (i == 0) ? b : 1'($urandom_range(0, 1)));
      end
    end
    rnd_en = 1'b0;
    wait_drain();

    // Reset with frame 1 partly drained and frame 2 partly loaded.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(101 + i), 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    obs.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(9 + i), 1'b0);
    wait_drain();
    chk("post_rst_count", 32'(obs.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      chk($sformatf("post_rst_out%0d", i), 32'(obs[i]),
          32'(rst_exp[i]));
    end

    // LOG_N=4, DATA_W=16 instance.
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      v4_in_valid = 1'b1;
      v4_in_data  = 16'(i);
      @(negedge clk);
      if (v4_in_ready) acc++;
      @(posedge clk);
      #1;
    end
    v4_in_valid = 1'b0;
    chk("n16_accepted", 32'(acc), 32'd16);
    got4 = 0;
    for (int c = 0; c < 60 && got4 < 16; c++) begin
      @(negedge clk);
      if (v4_out_valid) begin
        chk($sformatf("n16_out%0d", got4), 32'(v4_out_data),
            32'(exp4[got4]));
        chk($sformatf("n16_last%0d", got4), 32'(v4_out_last),
            32'(got4 == 15));
        got4++;
      end
    end
    chk("n16_count", 32'(got4), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
